// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding a single UART transmitter.
// Define UART_TX_SCHED_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_sched #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] ack,
  output logic       tx,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_SCHED_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic       stopCnt_q, stopCnt_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       owner_q, owner_d;
  logic       lastGrant_q, lastGrant_d;
  logic       winner;
  logic       canGrant;
  logic [7:0] winData;
`ifdef UART_TX_SCHED_PARITY_EN
  localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
  logic       parity_q, parity_d;
`endif

  // lastGrant_q resets to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bitCnt_q    <= '0;
      stopCnt_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      stopCnt_q   <= stopCnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    stopCnt_d   = stopCnt_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    canGrant    = 1'b0;
    ack         = 2'b00;
`ifdef UART_TX_SCHED_PARITY_EN
    parity_d    = parity_q;
`endif

    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~lastGrant_q;
    endcase
    winData = winner ? data1 : data0;

    case (state_q)
      IDLE: begin
        if (baud_tick && req != 2'b00) canGrant = 1'b1;
      end
      START: begin
        if (baud_tick) begin
          tx_d     = shift_q[0];
          bitCnt_d = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bitCnt_q == LAST_BIT) begin
`ifdef UART_TX_SCHED_PARITY_EN
            tx_d      = parity_q;
            state_d   = PARITY;
`else
            tx_d      = 1'b1;
            stopCnt_d = 1'b0;
            state_d   = STOP;
`endif
          end else begin
            shift_d  = shift_q >> 1;
            tx_d     = shift_q[1];
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_SCHED_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          tx_d      = 1'b1;
          stopCnt_d = 1'b0;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_tick) begin
          if (stopCnt_q == LAST_STOP) begin
            if (req != 2'b00) begin
              canGrant = 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            stopCnt_d = stopCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant overrides the per-state updates; the final stop tick chains straight into the next start bit.
    if (canGrant && !rst) begin
      ack         = winner ? 2'b10 : 2'b01;
      shift_d     = winData;
      owner_d     = winner;
      lastGrant_d = winner;
      busy_d      = 1'b1;
      tx_d        = 1'b0;
      state_d     = START;
`ifdef UART_TX_SCHED_PARITY_EN
      parity_d    = ^(winData & DATA_MASK);
`endif
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: an 8N1 instance and a 5-data/2-stop instance share
// clock, reset and a baud tick every 16 clocks; frames are checked bit by bit at each tick edge.
module tb_uart_tx_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] reqSmall = 2'b00;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [7:0] dataSmall1 = 8'h00;
  logic [1:0] ack, ackSmall;
  logic       tx, txSmall, busy, busySmall, owner, ownerSmall;
  logic       useSmall = 1'b0;
  logic [1:0] obsAck;
  logic       obsTx, obsBusy, obsOwner;
  int         checks = 0;
  int         passes = 0;
  int         divCnt = 0;

  uart_tx_sched #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req),
    .data0(data0), .data1(data1), .ack(ack), .tx(tx), .busy(busy), .owner(owner)
  );

  uart_tx_sched #(.DATA_BITS(5), .STOP_BITS(2)) dutSmall (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(reqSmall),
    .data0(8'h00), .data1(dataSmall1), .ack(ackSmall), .tx(txSmall),
    .busy(busySmall), .owner(ownerSmall)
  );

  assign obsAck   = useSmall ? ackSmall   : ack;
  assign obsTx    = useSmall ? txSmall    : tx;
  assign obsBusy  = useSmall ? busySmall  : busy;
  assign obsOwner = useSmall ? ownerSmall : owner;

  always #5 clk = ~clk;

  // Baud tick: one clock high out of every 16, changed shortly after the rising edge.
  always @(posedge clk) begin
    #2;
    if (divCnt == 15) begin
      divCnt    = 0;
      baud_tick = 1'b1;
    end else begin
      divCnt    = divCnt + 1;
      baud_tick = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] r);
    if (useSmall) reqSmall = r;
    else          req      = r;
  endtask

  // Returns ack as seen during the tick cycle, then lands 1 time unit after the tick edge.
  task automatic waitTickEdge(output logic [1:0] ackAtTick);
    int n = 0;
    @(negedge clk);
    while (baud_tick !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tickTimeout", 32'(n >= 40), 32'd0);
    ackAtTick = obsAck;
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runFrame(input logic [7:0] d, input int dbits, input int sbits,
                          input logic [1:0] expAck, input logic [1:0] reqAfter,
                          input bit last, input string tag);
    logic [1:0] a;
    logic [7:0] mask;
    waitTickEdge(a);
    checkOutput({tag, "_grantAck"}, 32'(a), 32'(expAck));
    checkOutput({tag, "_startTx"}, 32'(obsTx), 32'd0);
    checkOutput({tag, "_busy"}, 32'(obsBusy), 32'd1);
    checkOutput({tag, "_owner"}, 32'(obsOwner), 32'(expAck[1]));
    applyStimulus(reqAfter);
    mask = 8'h00;
    for (int i = 0; i < dbits; i++) begin
      mask[i] = 1'b1;
      waitTickEdge(a);
      checkOutput({tag, "_dataTx"}, 32'(obsTx), 32'(d[i]));
      checkOutput({tag, "_dataAck"}, 32'(a), 32'd0);
    end
`ifdef UART_TX_SCHED_PARITY_EN
    waitTickEdge(a);
    checkOutput({tag, "_parityTx"}, 32'(obsTx), 32'(^(d & mask)));
`endif
    waitTickEdge(a);
    checkOutput({tag, "_stopTx"}, 32'(obsTx), 32'd1);
    checkOutput({tag, "_stopBusy"}, 32'(obsBusy), 32'd1);
    for (int s = 1; s < sbits; s++) begin
      waitTickEdge(a);
      checkOutput({tag, "_stop2Tx"}, 32'(obsTx), 32'd1);
      checkOutput({tag, "_stop2Ack"}, 32'(a), 32'd0);
      checkOutput({tag, "_stop2Busy"}, 32'(obsBusy), 32'd1);
    end
    if (last) begin
      waitTickEdge(a);
      checkOutput({tag, "_endAck"}, 32'(a), 32'd0);
      checkOutput({tag, "_endBusy"}, 32'(obsBusy), 32'd0);
      checkOutput({tag, "_endTx"}, 32'(obsTx), 32'd1);
    end
  endtask

  initial begin
    logic [1:0] a;

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstTx", 32'(tx), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstAck", 32'(ack), 32'd0);
    checkOutput("rstOwner", 32'(owner), 32'd0);
    checkOutput("rstSmallTx", 32'(txSmall), 32'd1);
    rst = 1'b0;

    // Single requester, 0x55
    data0 = 8'h55;
    applyStimulus(2'b01);
    runFrame(8'h55, 8, 1, 2'b01, 2'b00, 1'b1, "f55");

    // Both requesting: alternating, back-to-back frames
    resetPulse();
    data0 = 8'hA0;
    data1 = 8'h0F;
    applyStimulus(2'b11);
    runFrame(8'hA0, 8, 1, 2'b01, 2'b11, 1'b0, "rr0");
    runFrame(8'h0F, 8, 1, 2'b10, 2'b11, 1'b0, "rr1");
    runFrame(8'hA0, 8, 1, 2'b01, 2'b11, 1'b0, "rr2");
    runFrame(8'h0F, 8, 1, 2'b10, 2'b00, 1'b1, "rr3");

    // Short request pulse between ticks is ignored
    waitTickEdge(a);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(2'b10);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("pulseAck", 32'(ack), 32'd0);
      checkOutput("pulseTx", 32'(tx), 32'd1);
      @(posedge clk);
      #1;
    end
    applyStimulus(2'b00);
    waitTickEdge(a);
    checkOutput("pulseTickAck", 32'(a), 32'd0);
    checkOutput("pulseTickTx", 32'(tx), 32'd1);
    checkOutput("pulseTickBusy", 32'(busy), 32'd0);

    // Reset during data bit 4, then priority back to requester 0
    data0 = 8'h00;
    applyStimulus(2'b01);
    waitTickEdge(a);
    checkOutput("abortGrantAck", 32'(a), 32'd1);
    applyStimulus(2'b00);
    repeat (5) waitTickEdge(a);
    repeat (3) @(negedge clk);
    checkOutput("abortBit4Tx", 32'(tx), 32'd0);
    applyStimulus(2'b11);
    rst = 1'b1;
    #1;
    checkOutput("abortTx", 32'(tx), 32'd1);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortAck", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitTickEdge(a);
    checkOutput("afterRstBothAck", 32'(a), 32'd1);
    checkOutput("afterRstBothOwner", 32'(owner), 32'd0);
    applyStimulus(2'b10);
    resetPulse();
    waitTickEdge(a);
    checkOutput("afterRstOneAck", 32'(a), 32'd2);
    checkOutput("afterRstOneOwner", 32'(owner), 32'd1);
    applyStimulus(2'b00);
    resetPulse();

`ifdef UART_TX_SCHED_PARITY_EN
    // Parity values
    data0 = 8'h07;
    applyStimulus(2'b01);
    runFrame(8'h07, 8, 1, 2'b01, 2'b00, 1'b1, "par07");
    data0 = 8'h03;
    applyStimulus(2'b01);
    runFrame(8'h03, 8, 1, 2'b01, 2'b00, 1'b1, "par03");
`endif

    // Five data bits, two stop bits
    useSmall = 1'b1;
    dataSmall1 = 8'h1F;
    applyStimulus(2'b10);
    runFrame(8'h1F, 5, 2, 2'b10, 2'b00, 1'b1, "small1F");
    useSmall = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1..2).
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port baud_tick  input  1  one-clk pulse per bit period, driven by the baud rate generator.
REQ-006 Port req  input  2  per-requester transmit request, level, held until ack.
REQ-007 Port data0  input  8  requester 0 byte, LSB first, valid while req[0]=1.
REQ-008 Port data1  input  8  requester 1 byte, LSB first, valid while req[1]=1.
REQ-009 Port ack  output  2  one-clk grant pulse, one-hot, data captured that cycle.
REQ-010 Port tx  output  1  registered serial line, idle high.
REQ-011 Port busy  output  1  high from the grant cycle until the frame's last stop bit completes.
REQ-012 Port owner  output  1  index of the requester whose frame is in flight, valid while busy=1.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP; all transitions occur only in cycles with baud_tick=1.
REQ-014 Arbitration SHALL occur only in IDLE, or in STOP on the final stop bit, in a cycle with baud_tick=1 and req!=0.
REQ-015 Arbitration SHALL be round-robin: single requester wins; if both request, the one not granted last wins; after reset requester 0 has priority.
REQ-016 Grant cycle: ack[winner]=1, shift register <= data of winner, owner <= winner, busy <= 1, tx <= 0, state <= START.
REQ-017 START on tick: tx <= shift[0], bit counter <= 0, state <= DATA.
REQ-018 DATA on tick: if counter = DATA_BITS-1, go to PARITY (macro) or STOP with tx <= 1; else shift right, tx <= next bit, counter+1.
REQ-019 STOP SHALL last STOP_BITS tick periods with tx=1; on the final tick, grant per REQ-016 if req!=0, else go to IDLE with busy <= 0.
REQ-020 Every bit SHALL occupy exactly one full tick-to-tick period; back-to-back frames SHALL have no idle gap.
REQ-021 req deasserted before grant SHALL produce no ack and no frame; changes to req/data after ack SHALL not affect the frame in flight.
REQ-022 In IDLE with baud_tick=0, req SHALL be held pending with no output change.
REQ-023 ack SHALL never be asserted outside a grant cycle and never for more than one clk per frame.

Reset
REQ-024 While rst=1, asynchronously: state=IDLE, tx=1, ack=0, busy=0, owner=0, counters=0, round-robin priority=requester 0.
REQ-025 Reset mid-frame SHALL abort the frame with tx high immediately; no ack is reissued for the aborted byte.

Configuration
REQ-026 Macro UART_TX_SCHED_PARITY_EN defined: PARITY state inserted after DATA for one tick period, tx = even parity (XOR) of the DATA_BITS data bits.
REQ-027 Macro undefined: no PARITY state, DATA proceeds directly to STOP; frame = 1+DATA_BITS+STOP_BITS bit periods.

Verification
REQ-028 req=01, data0=0x55, tick every 16 clk -> ack=01 on first tick, tx = 0,1,0,1,0,1,0,1,0,1 each 16 clk, busy drops after stop.
REQ-029 req=11 held, data0=0xA0, data1=0x0F -> frames owner 0, 1, 0, 1 alternating, back-to-back, no idle bit between.
REQ-030 req=10 pulsed for 3 clk between ticks -> no ack, tx stays 1, busy stays 0.
REQ-031 rst asserted during DATA bit 4 -> tx=1, busy=0, ack=0 same cycle; after release, req[1] served first only if req[0]=0.
REQ-032 UART_TX_SCHED_PARITY_EN defined, data0=0x07 -> parity bit 1; data0=0x03 -> parity bit 0; frame length 11 tick periods.
REQ-033 STOP_BITS=2, DATA_BITS=5, data1=0x1F -> tx: 0, 1x5, 1x2 periods, ack once only.
